// File: rtl/onoff_switch_bank_pkg.sv
// Shared definitions for the on/off switch bank: per-channel mode codes
// and a helper that sizes the debounce counter.
package onoff_switch_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_MOMENT = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_DIS    = 2'b11
  } mode_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int deb_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onoff_debounce.sv
// One switch channel front end: 2-flop synchroniser, debounce, press-edge detect.
// Latency: input stable before edge 0 -> deb high at edge DEB_CYCLES+1, press in that cycle.
// No backpressure; press is a single-cycle combinational pulse off registered state.
module onoff_debounce
  import onoff_switch_bank_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic sw_raw,
  output logic deb,
  output logic press
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic          deb_d;
  logic [CW-1:0] cnt;

  // Synchronise the raw level, then accept a new level only after it has
  // differed from the debounced level for DEB_CYCLES consecutive samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= sw_raw;
      s2    <= s1;
      deb_d <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = deb & ~deb_d;

endmodule

// File: rtl/onoff_switch_bank.sv
// N_CH independent switch channels, each giving a registered ON/OFF run enable.
// Latency: ONOFF responds one edge after the debounced press (DEB_CYCLES+2 edges from the switch).
// No backpressure; FORCE_OFF and RESET override every channel unconditionally.
module onoff_switch_bank
  import onoff_switch_bank_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_CH-1:0]      SW_IN,
  input  logic [2*N_CH-1:0]    MODE,
  input  logic [TIMEOUT_W-1:0] TIMEOUT,
  input  logic                 FORCE_OFF,
  output logic [N_CH-1:0]      ONOFF,
  output logic [N_CH-1:0]      EXPIRED
);

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic                 deb;
      logic                 press;
      mode_e                mode_cur;
      mode_e                mode_q;
      logic [TIMEOUT_W-1:0] timer;
      logic                 on_q;
      logic                 exp_q;
      logic                 at_limit;

      onoff_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .CLK    (CLK),
        .RESET  (RESET),
        .sw_raw (SW_IN[i]),
        .deb    (deb),
        .press  (press)
      );

      assign mode_cur = mode_e'(MODE[2*i +: 2]);

      // Expire when this cycle would be the TIMEOUT-th ON cycle; compared with
      // one extra bit so a timer at full scale cannot wrap past the limit.
      assign at_limit = (TIMEOUT != '0) &&
                        (({1'b0, timer} + {{TIMEOUT_W{1'b0}}, 1'b1}) >= {1'b0, TIMEOUT});

      // Per-channel state: FORCE_OFF, then disable, then press, then expiry.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          on_q   <= 1'b0;
          exp_q  <= 1'b0;
          timer  <= '0;
          mode_q <= MODE_TOGGLE;
        end else begin
          mode_q <= mode_cur;
          exp_q  <= 1'b0;
          if (FORCE_OFF) begin
            on_q  <= 1'b0;
            timer <= '0;
          end else begin
            case (mode_cur)
              MODE_MOMENT: begin
                on_q  <= deb;
                timer <= '0;
              end
              MODE_TOGGLE: begin
                if (press) on_q <= ~on_q;
                timer <= '0;
              end
              MODE_AUTO: begin
                if (press) begin
                  // Early press while ON turns off without EXPIRED, even if
                  // the timeout would have hit in this same cycle.
                  on_q  <= ~on_q;
                  timer <= '0;
                end else if (on_q && (mode_q != MODE_AUTO)) begin
                  // Arriving in auto-off while already ON restarts the count.
                  timer <= '0;
                end else if (on_q && at_limit) begin
                  on_q  <= 1'b0;
                  exp_q <= 1'b1;
                  timer <= '0;
                end else if (on_q) begin
                  timer <= timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                end else begin
                  timer <= '0;
                end
              end
              default: begin
                on_q  <= 1'b0;
                timer <= '0;
              end
            endcase
          end
        end
      end

      assign ONOFF[i]   = on_q;
      assign EXPIRED[i] = exp_q;
    end
  endgenerate

endmodule
